// File: rtl/code_frame_receiver.sv
// Frame-aligned serial receiver: hunts for SYNC_WORD, then deserialises FRAMES_PER_SYNC MSB-first
// words into a one-entry valid/ready output register. Define CODE_RX_PARITY_EN for a parity bit.
module code_frame_receiver #(
    parameter int unsigned       DATA_W          = 8,
    parameter int unsigned       SYNC_W          = 8,
    parameter logic [SYNC_W-1:0] SYNC_WORD       = 8'hA5,
    parameter int unsigned       FRAMES_PER_SYNC = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_input,
    input  logic              io_in_valid,
    input  logic              io_out_ready,
    input  logic              io_clear,
    output logic [DATA_W-1:0] io_out_data,
    output logic              io_out_valid,
    output logic              io_locked,
    output logic              io_overrun,
    output logic              io_parity_err
);

`ifdef CODE_RX_PARITY_EN
    localparam int unsigned BitsPerWord = DATA_W + 1;
    localparam int unsigned ShiftW      = DATA_W;
`else
    localparam int unsigned BitsPerWord = DATA_W;
    // The final data bit comes straight from io_input, so only DATA_W-1 bits are stored.
    localparam int unsigned ShiftW      = DATA_W - 1;
`endif
    localparam int unsigned CntW     = $clog2(BitsPerWord);
    localparam logic [CntW-1:0] LastBit  = CntW'(BitsPerWord - 1);
    localparam logic [7:0]      LastWord = 8'(FRAMES_PER_SYNC - 1);

    typedef enum logic [0:0] {StHunt, StData} state_e;

    state_e              r_state;
    logic [SYNC_W-1:0]   r_sync;
    logic [ShiftW-1:0]   r_shift;
    logic [CntW-1:0]     r_bit_cnt;
    logic [7:0]          r_word_cnt;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_valid;
    logic                r_overrun;

    logic [SYNC_W-1:0]   w_sync_next;
    logic [ShiftW-1:0]   w_shift_next;
    logic [DATA_W-1:0]   w_word;
    logic                w_done;
    logic                w_load;
    logic                w_drop;

    assign w_sync_next  = SYNC_W'({r_sync, io_input});
    assign w_shift_next = ShiftW'({r_shift, io_input});
    assign w_done       = (r_state == StData) && io_in_valid && (r_bit_cnt == LastBit);
    assign w_load       = w_done && (!r_out_valid || io_out_ready);
    assign w_drop       = w_done && r_out_valid && !io_out_ready;

`ifdef CODE_RX_PARITY_EN
    logic r_parity_err;
    logic w_parity_err;

    assign w_word       = r_shift;
    assign w_parity_err = ^{r_shift, io_input};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_parity_err <= 1'b0;
        end else if (w_load) begin
            r_parity_err <= w_parity_err;
        end
    end

    assign io_parity_err = r_parity_err;
`else
    assign w_word        = {r_shift, io_input};
    assign io_parity_err = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= StHunt;
            r_sync      <= '0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_word_cnt  <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (io_in_valid) begin
                unique case (r_state)
                    StHunt: begin
                        r_sync <= w_sync_next;
                        if (w_sync_next == SYNC_WORD) begin
                            r_state    <= StData;
                            r_bit_cnt  <= '0;
                            r_word_cnt <= '0;
                        end
                    end
                    StData: begin
                        r_shift <= w_shift_next;
                        if (w_done) begin
                            r_bit_cnt <= '0;
                            if (r_word_cnt == LastWord) begin
                                // Clearing the sync register stops frame bits aliasing a new sync.
                                r_state    <= StHunt;
                                r_sync     <= '0;
                                r_word_cnt <= '0;
                            end else begin
                                r_word_cnt <= r_word_cnt + 8'd1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                    default: r_state <= StHunt;
                endcase
            end

            if (w_load) begin
                r_out_data  <= w_word;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && io_out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (io_clear) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign io_out_data  = r_out_data;
    assign io_out_valid = r_out_valid;
    assign io_locked    = (r_state == StData);
    assign io_overrun   = r_overrun;

endmodule

// File: tb/tb_code_frame_receiver.sv
// Bench for code_frame_receiver: directed word table, hand-written corner sequences and a
// randomized run against a queue-based reference model.
module tb_code_frame_receiver;

`ifdef CODE_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int BPW = PAR ? 9 : 8;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       io_input = 1'b0;
    logic       io_in_valid = 1'b0;
    logic       io_out_ready = 1'b0;
    logic       io_clear = 1'b0;
    logic [7:0] io_out_data;
    logic       io_out_valid;
    logic       io_locked;
    logic       io_overrun;
    logic       io_parity_err;

    int total = 0;
    int bad = 0;

    code_frame_receiver dut (
        .clock        (clock),
        .reset        (reset),
        .io_input     (io_input),
        .io_in_valid  (io_in_valid),
        .io_out_ready (io_out_ready),
        .io_clear     (io_clear),
        .io_out_data  (io_out_data),
        .io_out_valid (io_out_valid),
        .io_locked    (io_locked),
        .io_overrun   (io_overrun),
        .io_parity_err(io_parity_err)
    );

    always #5 clock = ~clock;

    // Packed view: {valid, locked, overrun, parity_err, data}
    function automatic logic [11:0] outs();
        return {io_out_valid, io_locked, io_overrun, io_parity_err, io_out_data};
    endfunction

    function automatic logic [11:0] e(input bit v, input bit l, input bit o, input bit p,
                                      input logic [7:0] d);
        return {v, l, o, p, d};
    endfunction

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (valid,locked,overrun,parity_err,data)",
                     nm, act, exp);
        end
    endtask

    task automatic cyc(input bit b, input bit v, input bit r, input bit c);
        io_input = b;
        io_in_valid = v;
        io_out_ready = r;
        io_clear = c;
        @(posedge clock);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] val, input int n, input bit r, input bit rl);
        for (int i = n - 1; i >= 0; i--) cyc(val[i], 1'b1, (i == 0) ? rl : r, 1'b0);
    endtask

    task automatic send_word(input logic [7:0] w, input bit r, input bit rl);
        if (PAR) send_bits({23'd0, w, ^w}, 9, r, rl);
        else send_bits({24'd0, w}, 8, r, rl);
    endtask

    // Reference model state
    bit         m_locked;
    bit         hist[$];
    bit         wb[$];
    int         m_words;
    bit         m_valid;
    bit         m_ovr;
    bit         m_perr;
    logic [7:0] m_data;

    task automatic model_reset();
        m_locked = 0; hist.delete(); wb.delete(); m_words = 0;
        m_valid = 0; m_ovr = 0; m_perr = 0; m_data = 8'h00;
    endtask

    task automatic model_step(input bit b, input bit v, input bit r, input bit c);
        bit         done = 0;
        bit         drop = 0;
        int         val = 0;
        int         ones = 0;
        if (v) begin
            if (!m_locked) begin
                hist.push_back(b);
                if (hist.size() > 8) void'(hist.pop_front());
                if (hist.size() == 8) begin
                    foreach (hist[i]) val = val * 2 + int'(hist[i]);
                    if (val == 'hA5) begin
                        m_locked = 1; wb.delete(); m_words = 0;
                    end
                end
            end else begin
                wb.push_back(b);
                if (wb.size() == BPW) begin
                    for (int i = 0; i < 8; i++) val = val * 2 + int'(wb[i]);
                    foreach (wb[i]) ones += int'(wb[i]);
                    done = 1;
                    wb.delete();
                    m_words++;
                    if (m_words == 4) begin
                        m_locked = 0; hist.delete();
                    end
                end
            end
        end
        if (done && (!m_valid || r)) begin
            m_valid = 1; m_data = val[7:0]; m_perr = PAR ? bit'(ones % 2) : 1'b0;
        end else if (done) begin
            drop = 1;
        end else if (m_valid && r) begin
            m_valid = 0;
        end
        if (drop) m_ovr = 1;
        else if (c) m_ovr = 0;
    endtask

    typedef struct {
        logic [7:0]  w;
        bit          raw;
        bit          rdy;
        bit          rdy_last;
        logic [11:0] exp;
    } vec_t;

    vec_t vt[15];
    bit   src[$];

    initial begin
        vt[0]  = '{8'hA5, 1, 1, 1, e(0, 1, 0, 0, 8'h00)};
        vt[1]  = '{8'h3C, 0, 1, 1, e(1, 1, 0, 0, 8'h3C)};
        vt[2]  = '{8'h81, 0, 1, 1, e(1, 1, 0, 0, 8'h81)};
        vt[3]  = '{8'hFF, 0, 1, 1, e(1, 1, 0, 0, 8'hFF)};
        vt[4]  = '{8'h00, 0, 1, 1, e(1, 0, 0, 0, 8'h00)};
        vt[5]  = '{8'hF0, 1, 1, 1, e(0, 0, 0, 0, 8'h00)};
        vt[6]  = '{8'hA5, 1, 1, 1, e(0, 1, 0, 0, 8'h00)};
        vt[7]  = '{8'h12, 0, 1, 1, e(1, 1, 0, 0, 8'h12)};
        vt[8]  = '{8'h33, 0, 1, 1, e(1, 1, 0, 0, 8'h33)};
        vt[9]  = '{8'h11, 0, 1, 1, e(1, 1, 0, 0, 8'h11)};
        vt[10] = '{8'h22, 0, 0, 0, e(1, 0, 1, 0, 8'h11)};
        vt[11] = '{8'hA5, 1, 1, 1, e(0, 1, 0, 0, 8'h11)};
        vt[12] = '{8'h55, 0, 0, 0, e(1, 1, 0, 0, 8'h55)};
        vt[13] = '{8'h66, 0, 0, 1, e(1, 1, 0, 0, 8'h66)};
        vt[14] = '{8'h77, 0, 1, 1, e(1, 1, 0, 0, 8'h77)};

        repeat (2) @(posedge clock);
        #1;
        chk("reset_state", outs(), e(0, 0, 0, 0, 8'h00));
        reset = 1'b1;
        cyc(0, 0, 0, 0);

        for (int i = 0; i < 15; i++) begin
            if (vt[i].raw) send_bits({24'd0, vt[i].w}, 8, vt[i].rdy, vt[i].rdy_last);
            else send_word(vt[i].w, vt[i].rdy, vt[i].rdy_last);
            chk($sformatf("vec%0d", i), outs(), vt[i].exp);
            if (i == 10) begin
                cyc(0, 0, 0, 1);
                chk("clear_overrun", outs(), e(1, 0, 0, 0, 8'h11));
            end
        end
        send_word(8'h88, 1, 1);
        chk("frame3_end", outs(), e(1, 0, 0, 0, 8'h88));

        // Reset in the middle of a word, with the output register still full
        send_bits(32'hA5, 8, 0, 0);
        send_bits(32'h18, 5, 0, 0);
        chk("pre_reset", outs(), e(1, 1, 0, 0, 8'h88));
        reset = 1'b0;
        #1;
        chk("async_reset", outs(), e(0, 0, 0, 0, 8'h00));
        @(posedge clock);
        #1;
        reset = 1'b1;
        send_bits(32'hA5, 8, 1, 1);
        chk("relock", outs(), e(0, 1, 0, 0, 8'h00));
        send_word(8'h7E, 1, 1);
        chk("after_reset_word", outs(), e(1, 1, 0, 0, 8'h7E));
        repeat (3) cyc(0, 0, 1, 0);
        chk("single_word", outs(), e(0, 1, 0, 0, 8'h7E));

        if (PAR) begin
            reset = 1'b0;
            cyc(0, 0, 0, 0);
            reset = 1'b1;
            send_bits(32'hA5, 8, 1, 1);
            send_bits({23'd0, 8'h07, 1'b1}, 9, 1, 1);
            chk("parity_ok", outs(), e(1, 1, 0, 0, 8'h07));
            send_bits({23'd0, 8'h07, 1'b0}, 9, 1, 1);
            chk("parity_err", outs(), e(1, 1, 0, 1, 8'h07));
        end

        // Randomized run against the reference model
        reset = 1'b0;
        cyc(0, 0, 0, 0);
        reset = 1'b1;
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            bit b = 0;
            bit v = ($urandom_range(0, 9) != 0);
            bit r = ($urandom_range(0, 3) != 0);
            bit c = ($urandom_range(0, 15) == 0);
            if (src.size() == 0) begin
                logic [8:0] rnd = 9'($urandom);
                if ($urandom_range(0, 1) == 1) begin
                    logic [7:0] sw = 8'hA5;
                    for (int k = 7; k >= 0; k--) src.push_back(sw[k]);
                end else begin
                    for (int k = 8; k >= 9 - BPW; k--) src.push_back(rnd[k]);
                end
            end
            if (v) b = src.pop_front();
            model_step(b, v, r, c);
            cyc(b, v, r, c);
            chk("random", outs(), e(m_valid, m_locked, m_ovr, m_perr, m_data));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
